// File: rtl/led_breathe_cycler_pkg.sv
// ----------------------------------------------------------------------------
// led_breathe_cycler_pkg
// Shared definitions for the LED blocks: mode encodings, ramp FSM state
// encodings and the derivation of the full-scale brightness level.
// ----------------------------------------------------------------------------
package led_breathe_cycler_pkg;

  // Operating modes, as presented on the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_CYCLE = 2'b00,  // breathe one channel, advance at breath end
    MODE_ALL   = 2'b01,  // all channels breathe together
    MODE_HOLD  = 2'b10,  // current channel at constant full scale
    MODE_OFF   = 2'b11   // everything dark
  } mode_e;

  // Ramp FSM states.
  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } ramp_state_e;

  // Full-scale level for a PWM_W-bit brightness value: 2^PWM_W - 1.
  function automatic int unsigned max_level(input int unsigned pwm_w);
    return (32'd1 << pwm_w) - 32'd1;
  endfunction

endpackage

// File: rtl/led_breathe_cycler_pwm_gen.sv
// ----------------------------------------------------------------------------
// pwm_gen
// Free-running PWM_W-bit counter plus comparator. The output is high while
// the counter is below duty, so duty/2^PWM_W of every counter period.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (counter to 0)
//   duty     in   PWM_W  compare level
//   pwm_out  out  1      high while counter < duty
// ----------------------------------------------------------------------------
module pwm_gen #(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_out
);

  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] cnt_d;

  // Counter never stops; enable does not gate the PWM.
  always_comb begin
    cnt_d = cnt_q + PWM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pwm_out = (cnt_q < duty);

endmodule

// File: rtl/led_breathe_cycler.sv
// ----------------------------------------------------------------------------
// led_breathe_cycler
// Ramps a brightness level 0 -> MAX -> 0 ("a breath") one step per prescaler
// tick and drives it as PWM onto one LED (CYCLE, advancing channel at each
// breath end), all LEDs (ALL), one LED at full scale (HOLD) or none (OFF).
//
// Ports:
//   ICE_CLK      in   sole clock, rising edge
//   RST          in   synchronous active-high reset
//   enable       in   1 = run; 0 = freeze prescaler, level, state, channel
//   mode         in   2      mode_e encoding, sampled only between breaths
//   step_div     in   DIV_W  clocks per level step (0 behaves as 1)
//   leds         out  N_LEDS PWM LED outputs, active-high
//   channel      out  clog2(N_LEDS) active channel index
//   level        out  PWM_W  current brightness level
//   breath_done  out  1      one-cycle pulse after each breath ends
//   dbg_state    out  ramp FSM state (UP/DOWN)
// ----------------------------------------------------------------------------
module led_breathe_cycler
  import led_breathe_cycler_pkg::*;
#(
  parameter int unsigned N_LEDS = 5,
  parameter int unsigned PWM_W  = 8,
  parameter int unsigned DIV_W  = 16,
  localparam int unsigned CH_W  = $clog2(N_LEDS)
) (
  input  logic              ICE_CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  step_div,
  output logic [N_LEDS-1:0] leds,
  output logic [CH_W-1:0]   channel,
  output logic [PWM_W-1:0]  level,
  output logic              breath_done,
  output ramp_state_e       dbg_state
);

  localparam logic [PWM_W-1:0] MAX     = PWM_W'(max_level(PWM_W));
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_LEDS - 1);

  // --------------------------------------------------------------------------
  // Prescaler. The terminal count is latched at each wrap (and at reset) so a
  // step_div change only takes effect at the next wrap.
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] limit_q, limit_d;
  logic [DIV_W-1:0] step_lim;
  logic             tick;

  assign step_lim = (step_div == '0) ? '0 : (step_div - DIV_W'(1));
  assign tick     = (presc_q == limit_q);

  always_comb begin
    presc_d = presc_q;
    limit_d = limit_q;
    if (enable) begin
      if (tick) begin
        presc_d = '0;
        limit_d = step_lim;
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Ramp FSM, channel pointer and sampled mode.
  // --------------------------------------------------------------------------
  ramp_state_e      state_q, state_d;
  logic [PWM_W-1:0] level_q, level_d;
  logic [CH_W-1:0]  channel_q, channel_d;
  mode_e            mode_q, mode_d;
  logic             done_q, done_d;
  logic             step;

  assign step = tick & enable;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    channel_d = channel_q;
    mode_d    = mode_q;
    done_d    = 1'b0;

    // Mode is only taken while idle at the bottom of a breath; a step taken
    // in the same cycle still uses the old mode.
    if ((level_q == '0) && (state_q == ST_UP)) begin
      mode_d = mode_e'(mode);
    end

    if ((mode_q == MODE_HOLD) || (mode_q == MODE_OFF)) begin
      // Parked at the bottom; also pulls back a step taken on the cycle the
      // new mode was sampled.
      state_d = ST_UP;
      level_d = '0;
    end else if (step) begin
      unique case (state_q)
        ST_UP: begin
          if (level_q >= MAX - PWM_W'(1)) begin
            level_d = MAX;
            state_d = ST_DOWN;
          end else begin
            level_d = level_q + PWM_W'(1);
          end
        end
        ST_DOWN: begin
          if (level_q <= PWM_W'(1)) begin
            level_d = '0;
            state_d = ST_UP;
            done_d  = 1'b1;
            if (mode_q == MODE_CYCLE) begin
              channel_d = (channel_q == LAST_CH) ? '0 : channel_q + CH_W'(1);
            end
          end else begin
            level_d = level_q - PWM_W'(1);
          end
        end
        default: begin
          state_d = ST_UP;
          level_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      presc_q   <= '0;
      limit_q   <= step_lim;
      state_q   <= ST_UP;
      level_q   <= '0;
      channel_q <= '0;
      mode_q    <= MODE_OFF;
      done_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      limit_q   <= limit_d;
      state_q   <= state_d;
      level_q   <= level_d;
      channel_q <= channel_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output drive: one shared PWM fanned out through a channel mask.
  // --------------------------------------------------------------------------
  logic [PWM_W-1:0]  drive_level;
  logic [N_LEDS-1:0] chan_mask;
  logic              pwm_on;

  always_comb begin
    drive_level = '0;
    chan_mask   = '0;
    unique case (mode_q)
      MODE_CYCLE: begin
        drive_level = level_q;
        chan_mask   = N_LEDS'(1) << channel_q;
      end
      MODE_ALL: begin
        drive_level = level_q;
        chan_mask   = '1;
      end
      MODE_HOLD: begin
        drive_level = MAX;
        chan_mask   = N_LEDS'(1) << channel_q;
      end
      default: begin
        drive_level = '0;
        chan_mask   = '0;
      end
    endcase
  end

  pwm_gen #(
    .PWM_W (PWM_W)
  ) u_pwm_gen (
    .clk     (ICE_CLK),
    .rst     (RST),
    .duty    (drive_level),
    .pwm_out (pwm_on)
  );

  assign leds        = chan_mask & {N_LEDS{pwm_on}};
  assign channel     = channel_q;
  assign level       = level_q;
  assign breath_done = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_led_breathe_cycler.sv
// ----------------------------------------------------------------------------
// tb_led_breathe_cycler
// Directed bench for led_breathe_cycler with N_LEDS=5, PWM_W=4 (MAX=15).
// Outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_led_breathe_cycler;
  import led_breathe_cycler_pkg::*;

  localparam int N_LEDS = 5;
  localparam int PWM_W  = 4;
  localparam int DIV_W  = 16;

  // clock / reset
  logic              ICE_CLK;
  logic              RST;
  logic              enable;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  step_div;
  logic [N_LEDS-1:0] leds;
  logic [2:0]        channel;
  logic [PWM_W-1:0]  level;
  logic              breath_done;
  ramp_state_e       dbg_state;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int n_hi, n_other, n_bd, n_odd;

  led_breathe_cycler #(
    .N_LEDS (N_LEDS),
    .PWM_W  (PWM_W),
    .DIV_W  (DIV_W)
  ) dut (
    .ICE_CLK     (ICE_CLK),
    .RST         (RST),
    .enable      (enable),
    .mode        (mode),
    .step_div    (step_div),
    .leds        (leds),
    .channel     (channel),
    .level       (level),
    .breath_done (breath_done),
    .dbg_state   (dbg_state)
  );

  initial ICE_CLK = 1'b0;
  always #5 ICE_CLK = ~ICE_CLK;

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge ICE_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; enable = 1'b0; mode = MODE_CYCLE; step_div = 16'd2;
    cyc(3);
    chk("rst_level", 32'(level), 0);
    chk("rst_channel", 32'(channel), 0);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_done", 32'(breath_done), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_UP));

    // Release with enable low: mode CYCLE is sampled, level 0 -> dark.
    RST = 1'b0;
    n_hi = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (leds != '0) n_hi++;
    end
    chk("lvl0_dark", 32'(n_hi), 0);
    chk("frozen_lvl0", 32'(level), 0);

    // CYCLE, step_div=2: one step every 2 clocks.
    enable = 1'b1;
    cyc(1);  chk("e0_level", 32'(level), 0);
    cyc(1);  chk("e1_level", 32'(level), 1);
    chk("e1_state", 32'(dbg_state), 32'(ST_UP));
    cyc(28); chk("peak_level", 32'(level), 15);
    chk("peak_state", 32'(dbg_state), 32'(ST_DOWN));
    chk("peak_channel", 32'(channel), 0);
    n_bd = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (breath_done) n_bd++;
    end
    chk("b1_end_level", 32'(level), 0);
    chk("b1_end_channel", 32'(channel), 1);
    chk("b1_done_count", 32'(n_bd), 1);
    chk("b1_done_now", 32'(breath_done), 1);
    cyc(1);  chk("b1_done_width", 32'(breath_done), 0);
    cyc(7);  chk("b2_level4", 32'(level), 4);

    // Freeze at level 4: duty 4/16 on channel 1 only.
    enable = 1'b0;
    n_hi = 0; n_other = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (leds[1]) n_hi++;
      if ((leds & 5'b11101) != '0) n_other++;
    end
    chk("duty4_high", 32'(n_hi), 4);
    chk("duty4_other", 32'(n_other), 0);
    chk("duty4_level", 32'(level), 4);

    // Resume, switch to ALL at level 7: this breath stays on one LED.
    enable = 1'b1;
    cyc(6);  chk("b2_level7", 32'(level), 7);
    mode = MODE_ALL;
    n_other = 0; n_bd = 0;
    for (int i = 0; i < 46; i++) begin
      cyc(1);
      if ((leds & 5'b11101) != '0) n_other++;
      if (breath_done) n_bd++;
    end
    chk("b2_single_led", 32'(n_other), 0);
    chk("b2_done_count", 32'(n_bd), 1);
    chk("b2_end_level", 32'(level), 0);
    chk("b2_end_channel", 32'(channel), 2);

    // ALL breath: every bit identical; go to level 9 on the way down.
    n_odd = 0;
    for (int i = 0; i < 42; i++) begin
      cyc(1);
      if (leds != '0 && leds != 5'h1F) n_odd++;
    end
    chk("all_identical", 32'(n_odd), 0);
    chk("all_level9", 32'(level), 9);
    chk("all_state_down", 32'(dbg_state), 32'(ST_DOWN));

    // enable=0 for 20 cycles at level 9 in DOWN.
    enable = 1'b0;
    n_hi = 0; n_odd = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (i < 16 && leds == 5'h1F) n_hi++;
      if (leds != '0 && leds != 5'h1F) n_odd++;
    end
    chk("duty9_high", 32'(n_hi), 9);
    chk("duty9_identical", 32'(n_odd), 0);
    chk("hold_level", 32'(level), 9);
    chk("hold_state", 32'(dbg_state), 32'(ST_DOWN));
    chk("hold_channel", 32'(channel), 2);
    enable = 1'b1;
    cyc(1);  chk("resume_level9", 32'(level), 9);
    cyc(1);  chk("resume_level8", 32'(level), 8);
    chk("resume_state", 32'(dbg_state), 32'(ST_DOWN));
    cyc(16); chk("all_end_level", 32'(level), 0);
    chk("all_end_channel", 32'(channel), 2);
    chk("all_end_done", 32'(breath_done), 1);

    // step_div=0: one step per clock, 30-clock breaths; channel wraps.
    mode = MODE_CYCLE; step_div = 16'd0;
    cyc(1);  chk("fast_l0", 32'(level), 0);
    cyc(1);  chk("fast_l1", 32'(level), 1);
    cyc(1);  chk("fast_l2", 32'(level), 2);
    cyc(28); chk("fast_b1_level", 32'(level), 0);
    chk("fast_b1_channel", 32'(channel), 3);
    chk("fast_b1_done", 32'(breath_done), 1);
    cyc(30); chk("fast_b2_channel", 32'(channel), 4);
    chk("fast_b2_done", 32'(breath_done), 1);
    cyc(30); chk("wrap_channel", 32'(channel), 0);
    chk("wrap_done", 32'(breath_done), 1);

    // HOLD: channel 0 at 15/16, no breath pulses, FSM parked.
    mode = MODE_HOLD;
    cyc(2);  chk("hold_mode_level", 32'(level), 0);
    n_hi = 0; n_other = 0; n_bd = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (leds[0]) n_hi++;
      if ((leds & 5'b11110) != '0) n_other++;
      if (breath_done) n_bd++;
    end
    chk("hold_duty", 32'(n_hi), 15);
    chk("hold_other", 32'(n_other), 0);
    chk("hold_no_done", 32'(n_bd), 0);
    chk("hold_parked", 32'(level), 0);

    // OFF: all dark.
    mode = MODE_OFF;
    cyc(1);
    n_hi = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (leds != '0) n_hi++;
    end
    chk("off_dark", 32'(n_hi), 0);

    // Reset mid-ramp on channel 1.
    mode = MODE_CYCLE;
    cyc(31); chk("pre_rst_channel", 32'(channel), 1);
    chk("pre_rst_done", 32'(breath_done), 1);
    cyc(7);  chk("pre_rst_level", 32'(level), 7);
    RST = 1'b1;
    n_bd = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (breath_done) n_bd++;
    end
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_channel", 32'(channel), 0);
    chk("mid_rst_leds", 32'(leds), 0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_UP));
    chk("mid_rst_no_done", 32'(n_bd), 0);
    RST = 1'b0;
    cyc(2);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
